// File: rtl/keypoint_extractor.sv
// keypoint_extractor
//   Scans the FAST corner map in SRAM4 in raster order and emits one (x,y)
//   record per non-zero corner flag on a valid/ready stream. The records pass
//   through a small first-word-fall-through FIFO.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, max_x, max_y frame start pulse and last column/row index (latched on start)
//   SRAM4_in            corner-map read data, valid the cycle after read_SRAM4
//   read_SRAM4, x_addr4, y_addr4  SRAM4 read strobe and address
//   kp_valid, kp_ready, kp_x, kp_y  keypoint stream (FIFO head)
//   kp_count            keypoints pushed this frame
//   busy, done          not-IDLE flag, 1-cycle frame-drained pulse
module keypoint_extractor #(
  parameter int X_MAX      = 5,
  parameter int Y_MAX      = 5,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(X_MAX) + 1,
  localparam int MW = $clog2(X_MAX),
  localparam int CW = 2 * MW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [MW-1:0] max_x,
  input  logic [MW-1:0] max_y,
  input  logic [7:0]    SRAM4_in,
  output logic          read_SRAM4,
  output logic [AW-1:0] x_addr4,
  output logic [AW-1:0] y_addr4,
  output logic          kp_valid,
  input  logic          kp_ready,
  output logic [AW-1:0] kp_x,
  output logic [AW-1:0] kp_y,
  output logic [CW-1:0] kp_count,
  output logic          busy,
  output logic          done
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] x;
    logic [AW-1:0] y;
  } kp_t;

  state_t        state, state_nx;
  logic [MW-1:0] mx_q, my_q;
  logic [AW-1:0] x_pos, y_pos;
  logic [AW-1:0] xa_q, ya_q;
  kp_t           mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fcnt;
  logic          full, empty, push, pop, rd_go, last_col, last_row;

  assign empty = (fcnt == '0);
  assign full  = (fcnt == (PW+1)'(FIFO_DEPTH));
  // A read is only issued with a slot free, so the following push always fits.
  assign rd_go = (state == READ) && !full;
  assign push  = (state == CAPTURE) && (SRAM4_in != 8'd0);
  assign pop   = !empty && kp_ready;

  // Bounds also clamp to the physical map size in case max_x/max_y overshoot.
  assign last_col = (x_pos == AW'(mx_q)) || (x_pos == AW'(X_MAX - 1));
  assign last_row = (y_pos == AW'(my_q)) || (y_pos == AW'(Y_MAX - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    if (!full) state_nx = CAPTURE;
      CAPTURE: state_nx = (last_col && last_row) ? DRAIN : READ;
      DRAIN:   if (empty) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address is live during the issuing cycle and holds afterwards.
  assign read_SRAM4 = rd_go;
  assign x_addr4    = rd_go ? x_pos : xa_q;
  assign y_addr4    = rd_go ? y_pos : ya_q;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign kp_valid   = !empty;
  assign kp_x       = mem[rd_ptr].x;
  assign kp_y       = mem[rd_ptr].y;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mx_q     <= '0;
      my_q     <= '0;
      x_pos    <= '0;
      y_pos    <= '0;
      xa_q     <= '0;
      ya_q     <= '0;
      kp_count <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fcnt     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        mx_q     <= max_x;
        my_q     <= max_y;
        x_pos    <= '0;
        y_pos    <= '0;
        kp_count <= '0;
      end
      if (rd_go) begin
        xa_q <= x_pos;
        ya_q <= y_pos;
      end
      if (state == CAPTURE) begin
        if (push) kp_count <= kp_count + CW'(1);
        if (last_col) begin
          x_pos <= '0;
          y_pos <= y_pos + AW'(1);
        end else begin
          x_pos <= x_pos + AW'(1);
        end
      end
      if (push) begin
        mem[wr_ptr] <= '{x: x_pos, y: y_pos};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fcnt <= fcnt + (PW+1)'(1);
        2'b01:   fcnt <= fcnt - (PW+1)'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

endmodule

// File: tb/tb_keypoint_extractor.sv
// tb_keypoint_extractor
//   Directed bench for keypoint_extractor: table of whole-frame vectors with
//   hand-computed keypoint counts and done latencies, plus hand sequences for
//   reset, back-pressure stall, mid-frame reset and ignored re-start.
module tb_keypoint_extractor;

  localparam int AW = 4;
  localparam int MW = 3;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [MW-1:0] max_x = '0;
  logic [MW-1:0] max_y = '0;
  logic [7:0]    SRAM4_in;
  logic          read_SRAM4;
  logic [AW-1:0] x_addr4, y_addr4;
  logic          kp_valid;
  logic          kp_ready = 1'b0;
  logic [AW-1:0] kp_x, kp_y;
  logic [CW-1:0] kp_count;
  logic          busy, done;

  keypoint_extractor #(.X_MAX(5), .Y_MAX(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .max_x(max_x), .max_y(max_y),
    .SRAM4_in(SRAM4_in), .read_SRAM4(read_SRAM4), .x_addr4(x_addr4),
    .y_addr4(y_addr4), .kp_valid(kp_valid), .kp_ready(kp_ready),
    .kp_x(kp_x), .kp_y(kp_y), .kp_count(kp_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Corner map model: bit y*5+x set means a corner at (x,y).
  logic [24:0] cur_map = '0;
  int          cur_mx  = 0;
  logic [7:0]  sram_q  = '0;
  assign SRAM4_in = sram_q;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (read_SRAM4) begin
      if (x_addr4 < 5 && y_addr4 < 5 && cur_map[int'(y_addr4) * 5 + int'(x_addr4)])
        sram_q <= 8'h01 << ((x_addr4 + y_addr4) % 8);
      else
        sram_q <= 8'h00;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: read strobe spacing and addresses, popped records, done pulses.
  int reads = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int mon_x = 0, mon_y = 0;
  bit prev_rd = 0;
  int got_q[$];

  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 0;
    end else begin
      if (read_SRAM4) begin
        chk("rd_gap", int'(prev_rd), 0);
        chk("rd_addr", int'(x_addr4) * 16 + int'(y_addr4), mon_x * 16 + mon_y);
        reads++;
        if (mon_x == cur_mx) begin
          mon_x = 0;
          mon_y++;
        end else begin
          mon_x++;
        end
      end
      prev_rd = read_SRAM4;
      if (kp_valid && kp_ready) got_q.push_back(int'(kp_x) * 16 + int'(kp_y));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_frame(input int mx, input int my, input logic [24:0] map);
    @(posedge clk); #1;
    cur_map = map;
    cur_mx  = mx;
    reads = 0; done_cnt = 0; mon_x = 0; mon_y = 0;
    got_q.delete();
    max_x = MW'(mx);
    max_y = MW'(my);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done_cnt == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_stream(input int mx, input int my, input logic [24:0] map);
    int exp_q[$];
    for (int y = 0; y <= my; y++)
      for (int x = 0; x <= mx; x++)
        if (map[y * 5 + x]) exp_q.push_back(x * 16 + y);
    chk("stream_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("stream_xy", got_q[i], exp_q[i]);
  endtask

  typedef struct {
    int          mx;
    int          my;
    logic [24:0] map;
    int          exp_count;
    int          exp_done;   // cycles from start cycle to done, ready held high
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{2, 1, 25'h0000082, 2, 15};
    vecs[1] = '{2, 1, 25'h0000000, 0, 14};
    vecs[2] = '{0, 0, 25'h0000001, 1, 5};
    vecs[3] = '{4, 4, 25'h1041041, 5, 53};
    vecs[4] = '{3, 0, 25'h1FFFFFF, 4, 11};
    vecs[5] = '{0, 2, 25'h0000020, 1, 8};

    // Reset held 3 cycles with start asserted.
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_read", int'(read_SRAM4), 0);
    chk("rst_valid", int'(kp_valid), 0);
    chk("rst_count", int'(kp_count), 0);
    chk("rst_addr", int'(x_addr4) + int'(y_addr4), 0);
    chk("rst_kpxy", int'(kp_x) + int'(kp_y), 0);
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy", int'(busy), 0);

    // Table-driven frames with ready always high.
    kp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].mx, vecs[i].my, vecs[i].map);
      wait_done(200);
      chk("reads", reads, (vecs[i].mx + 1) * (vecs[i].my + 1));
      chk("done_pulses", done_cnt, 1);
      chk("done_latency", done_cyc - start_cyc, vecs[i].exp_done);
      chk("kp_count", int'(kp_count), vecs[i].exp_count);
      chk("idle_busy", int'(busy), 0);
      chk_stream(vecs[i].mx, vecs[i].my, vecs[i].map);
    end

    // Back-pressure: all-ones map, ready low for 30 cycles.
    kp_ready = 1'b0;
    start_frame(2, 1, 25'h1FFFFFF);
    repeat (30) @(negedge clk);
    chk("stall_reads", reads, 4);
    chk("stall_valid", int'(kp_valid), 1);
    chk("stall_head", int'(kp_x) * 16 + int'(kp_y), 0);
    chk("stall_busy", int'(busy), 1);
    @(posedge clk); #1;
    kp_ready = 1'b1;
    wait_done(200);
    chk("stall_done", done_cnt, 1);
    chk("stall_count", int'(kp_count), 6);
    chk_stream(2, 1, 25'h1FFFFFF);

    // Reset after the third read aborts without done.
    start_frame(2, 1, 25'h0000082);
    begin
      int n;
      n = 0;
      while (reads < 3 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("rst3_reached", reads, 3);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(kp_valid), 0);
    chk("abort_count", int'(kp_count), 0);
    chk("abort_read", int'(read_SRAM4), 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    start_frame(2, 1, 25'h0000082);
    wait_done(200);
    chk("rescan_reads", reads, 6);
    chk("rescan_count", int'(kp_count), 2);
    chk_stream(2, 1, 25'h0000082);

    // Start re-pulsed while busy with different bounds is ignored.
    start_frame(2, 1, 25'h0000082);
    repeat (3) @(posedge clk);
    #1;
    max_x = '0;
    max_y = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    chk("restart_reads", reads, 6);
    chk("restart_done", done_cnt, 1);
    chk("restart_count", int'(kp_count), 2);
    chk_stream(2, 1, 25'h0000082);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
